// File: rtl/cart_pkg.sv
// Shared definitions for the cart ROM path: scheduler states, scheduler defaults
// and the cart type codes used by the mapper.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } sched_state_t;

  localparam int TIMEOUT_DEFAULT       = 15;
  localparam int RD_STREAK_MAX_DEFAULT = 4;

  localparam logic [7:0] CART_ROM_ONLY      = 8'h00;
  localparam logic [7:0] CART_MBC1          = 8'h01;
  localparam logic [7:0] CART_MBC1_RAM      = 8'h02;
  localparam logic [7:0] CART_MBC1_RAM_BATT = 8'h03;

endpackage

// File: rtl/cart_rom_sched.sv
// Shares the cart ROM memory port between mapper fetches and the image loader,
// with a one-entry read cache, a one-deep pending read and ack timeout recovery.
module cart_rom_sched
  import cart_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int TIMEOUT       = TIMEOUT_DEFAULT,
  parameter int RD_STREAK_MAX = RD_STREAK_MAX_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_drop,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int                  STREAK_W   = $clog2(RD_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(RD_STREAK_MAX);
  localparam logic [3:0]          TMO_LAST   = 4'(TIMEOUT - 1);

  sched_state_t        state_q;
  logic [3:0]          tmo_q;
  logic [STREAK_W-1:0] streak_q;

  logic                cache_valid_q;
  logic [ADDR_W-1:0]   cache_addr_q;
  logic [7:0]          cache_data_q;

  logic                pend_valid_q;
  logic [ADDR_W-1:0]   pend_addr_q;

  logic                ld_busy_q;
  logic                ld_pend_q;
  logic [ADDR_W-1:0]   ld_addr_q;
  logic [7:0]          ld_data_q;

  logic                resp_valid_q;
  logic [7:0]          resp_data_q;

  logic                rd_valid_q;
  logic [7:0]          rd_data_q;
  logic                rd_drop_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                err_q;

  logic hit, miss, tmo_fire, rd_finish, wr_finish, grant_rd, grant_wr;
  logic       out_valid_d;
  logic [7:0] out_data_d;
  logic       resp_valid_d;
  logic [7:0] resp_data_d;

  // Hit check uses the registered cache, so a request in the ack cycle sees pre-ack contents.
  assign hit       = rd_req && cache_valid_q && (rd_addr == cache_addr_q);
  assign miss      = rd_req && !hit;
  assign tmo_fire  = (state_q != IDLE) && !mem_ack && (tmo_q == TMO_LAST);
  assign rd_finish = (state_q == RD) && (mem_ack || tmo_fire);
  assign wr_finish = (state_q == WR) && (mem_ack || tmo_fire);
  assign grant_rd  = (state_q == IDLE) && pend_valid_q && (!ld_pend_q || (streak_q < STREAK_MAX));
  assign grant_wr  = (state_q == IDLE) && ld_pend_q && !grant_rd;

  // Miss completion owns the response slot; a colliding hit waits one cycle in resp.
  always_comb begin
    out_valid_d  = 1'b0;
    out_data_d   = rd_data_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    if (rd_finish) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_ack ? mem_rdata : 8'hFF;
      if (hit) begin
        resp_valid_d = 1'b1;
        resp_data_d  = cache_data_q;
      end
    end else if (resp_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = resp_data_q;
      resp_valid_d = hit;
      if (hit) resp_data_d = cache_data_q;
    end else if (hit) begin
      out_valid_d = 1'b1;
      out_data_d  = cache_data_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      streak_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      ld_busy_q     <= 1'b0;
      ld_pend_q     <= 1'b0;
      ld_addr_q     <= '0;
      ld_data_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_drop_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      rd_valid_q   <= out_valid_d;
      rd_data_q    <= out_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;

      rd_drop_q <= miss && pend_valid_q && !grant_rd;
      if (miss) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= rd_addr;
      end else if (grant_rd) begin
        pend_valid_q <= 1'b0;
      end

      if (ld_req && !ld_busy_q) begin
        ld_busy_q <= 1'b1;
        ld_pend_q <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end else if (wr_finish) begin
        ld_busy_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            state_q    <= RD;
            tmo_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pend_addr_q;
            if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
          end else if (grant_wr) begin
            state_q     <= WR;
            tmo_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ld_addr_q;
            mem_wdata_q <= ld_data_q;
            streak_q    <= '0;
            ld_pend_q   <= 1'b0;
            if (ld_addr_q == cache_addr_q) cache_valid_q <= 1'b0;
          end
        end
        RD, WR: begin
          if (mem_ack || tmo_fire) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (tmo_fire) err_q <= 1'b1;
            if (state_q == RD && mem_ack) begin
              cache_valid_q <= 1'b1;
              cache_addr_q  <= mem_addr_q;
              cache_data_q  <= mem_rdata;
            end
          end else begin
            tmo_q <= tmo_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_drop   = rd_drop_q;
  assign ld_busy   = ld_busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cart_rom_sched.sv
// Directed bench for cart_rom_sched: cache hit/miss, loader writes, starvation guard,
// pending overwrite, timeout, async reset and response collisions.
module tb_cart_rom_sched;

  logic        clock;
  logic        reset;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_drop;
  logic        ld_req;
  logic [17:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_busy;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cart_rom_sched #(.ADDR_W(18), .TIMEOUT(15), .RD_STREAK_MAX(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_drop  (rd_drop),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_busy  (ld_busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; ld_req = 1'b0; ld_addr = '0;
    ld_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    $display("reset: rd_data=%02h mem_req=%0b ld_busy=%0b err=%0b", rd_data, mem_req, ld_busy, err);
    total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %02h want 00", rd_data); else pass_cnt++;
    total_cnt++; if ({rd_valid, rd_drop} !== 2'b00) $display("FAIL reset_pulses: got %02b want 00", {rd_valid, rd_drop}); else pass_cnt++;
    total_cnt++; if ({mem_req, mem_we, ld_busy, err} !== 4'b0000) $display("FAIL reset_ctrl: got %04b want 0000", {mem_req, mem_we, ld_busy, err}); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata} !== 26'h0) $display("FAIL reset_bus: got %07h want 0", {mem_addr, mem_wdata}); else pass_cnt++;
  endtask

  task automatic test_miss_then_hit();
    rd_req = 1'b1; rd_addr = 18'h01234;
    tick();
    rd_req = 1'b0;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL miss_c1_req: got %0b want 0", mem_req); else pass_cnt++;
    tick();
    total_cnt++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 18'h01234)
      $display("FAIL miss_c2_bus: got req/we=%02b addr=%05h want 10 01234", {mem_req, mem_we}, mem_addr); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL miss_req_held: got %0b want 1", mem_req); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    $display("miss read 01234: rd_valid=%0b rd_data=%02h", rd_valid, rd_data);
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) $display("FAIL miss_resp: got v=%0b d=%02h want 1 5a", rd_valid, rd_data); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL miss_req_drop: got %0b want 0", mem_req); else pass_cnt++;
    tick();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL miss_pulse: got %0b want 0", rd_valid); else pass_cnt++;
    rd_req = 1'b1; rd_addr = 18'h01234;
    tick();
    rd_req = 1'b0;
    $display("hit read 01234: rd_valid=%0b rd_data=%02h", rd_valid, rd_data);
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) $display("FAIL hit_resp: got v=%0b d=%02h want 1 5a", rd_valid, rd_data); else pass_cnt++;
    tick();
    total_cnt++; if ({mem_req, rd_valid} !== 2'b00) $display("FAIL hit_no_mem: got req/v=%02b want 00", {mem_req, rd_valid}); else pass_cnt++;
  endtask

  task automatic test_load_invalidate();
    ld_req = 1'b1; ld_addr = 18'h01234; ld_data = 8'h77;
    tick();
    ld_req = 1'b0;
    total_cnt++; if (ld_busy !== 1'b1) $display("FAIL ld_busy_rise: got %0b want 1", ld_busy); else pass_cnt++;
    tick();
    total_cnt++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 18'h01234 || mem_wdata !== 8'h77)
      $display("FAIL ld_bus: got req/we=%02b addr=%05h wd=%02h want 11 01234 77", {mem_req, mem_we}, mem_addr, mem_wdata); else pass_cnt++;
    mem_ack = 1'b1;
    total_cnt++; if (ld_busy !== 1'b1) $display("FAIL ld_busy_ack_cycle: got %0b want 1", ld_busy); else pass_cnt++;
    tick();
    mem_ack = 1'b0;
    $display("write 01234 <= 77: ld_busy=%0b mem_req=%0b", ld_busy, mem_req);
    total_cnt++; if ({ld_busy, mem_req} !== 2'b00) $display("FAIL ld_done: got busy/req=%02b want 00", {ld_busy, mem_req}); else pass_cnt++;
    rd_req = 1'b1; rd_addr = 18'h01234;
    tick();
    rd_req = 1'b0;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL inval_no_hit: got %0b want 0", rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 18'h01234)
      $display("FAIL inval_reread: got req/we=%02b addr=%05h want 10 01234", {mem_req, mem_we}, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    $display("reread 01234: rd_valid=%0b rd_data=%02h", rd_valid, rd_data);
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h77}) $display("FAIL inval_resp: got v=%0b d=%02h want 1 77", rd_valid, rd_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_starvation();
    logic        we_log [0:7];
    logic [17:0] addr_log [0:7];
    logic [6:0]  we_vec;
    logic        prev_req;
    int n_log, issued, req_cnt, cyc, drops;
    n_log = 0; issued = 0; req_cnt = 0; cyc = 0; drops = 0; prev_req = 1'b0; we_vec = '0;
    do_reset();
    ld_req = 1'b1; ld_addr = 18'h3F000; ld_data = 8'hA5;
    rd_req = 1'b1; rd_addr = 18'h00400; issued = 1;
    tick();
    while ((n_log < 7 || mem_req) && cyc < 300) begin
      rd_req = 1'b0; ld_req = 1'b0; mem_ack = 1'b0;
      if (rd_drop) drops++;
      if (mem_req && !prev_req) begin
        if (n_log < 8) begin
          we_log[n_log]   = mem_we;
          addr_log[n_log] = mem_addr;
        end
        $display("grant %0d: we=%0b addr=%05h", n_log, mem_we, mem_addr);
        n_log++;
        if (!mem_we && issued < 6) begin
          rd_req = 1'b1; rd_addr = 18'h00400 + 18'(issued); issued++;
        end
      end
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 3) begin mem_ack = 1'b1; mem_rdata = mem_addr[7:0]; end
      end else begin
        req_cnt = 0;
      end
      prev_req = mem_req;
      tick();
      cyc++;
    end
    mem_ack = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 7; i++) if (i < n_log) we_vec[i] = we_log[i];
    total_cnt++; if (cyc >= 300) $display("FAIL starve_timeout: got %0d cycles want <300", cyc); else pass_cnt++;
    total_cnt++; if (n_log !== 7) $display("FAIL starve_grants: got %0d want 7", n_log); else pass_cnt++;
    total_cnt++; if (we_vec !== 7'b0010000) $display("FAIL starve_order: got %07b want 0010000", we_vec); else pass_cnt++;
    total_cnt++; if (addr_log[3] !== 18'h00403 || addr_log[4] !== 18'h3F000 || addr_log[6] !== 18'h00405)
      $display("FAIL starve_addrs: got %05h %05h %05h want 00403 3f000 00405", addr_log[3], addr_log[4], addr_log[6]); else pass_cnt++;
    total_cnt++; if (drops !== 0) $display("FAIL starve_drops: got %0d want 0", drops); else pass_cnt++;
    tick();
  endtask

  task automatic test_pending_overwrite();
    rd_req = 1'b1; rd_addr = 18'h00300;
    tick(); rd_req = 1'b0;
    tick();
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 18'h00300) $display("FAIL pend_rd_start: got req=%0b addr=%05h want 1 00300", mem_req, mem_addr); else pass_cnt++;
    rd_req = 1'b1; rd_addr = 18'h00100;
    tick();
    rd_addr = 18'h00200;
    total_cnt++; if (rd_drop !== 1'b0) $display("FAIL pend_first_nodrop: got %0b want 0", rd_drop); else pass_cnt++;
    tick();
    rd_req = 1'b0;
    $display("overwrite 00100 by 00200: rd_drop=%0b", rd_drop);
    total_cnt++; if (rd_drop !== 1'b1) $display("FAIL pend_drop: got %0b want 1", rd_drop); else pass_cnt++;
    tick();
    total_cnt++; if (rd_drop !== 1'b0) $display("FAIL pend_drop_pulse: got %0b want 0", rd_drop); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick(); mem_ack = 1'b0;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h11}) $display("FAIL pend_first_resp: got v=%0b d=%02h want 1 11", rd_valid, rd_data); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 18'h00200) $display("FAIL pend_next_addr: got req=%0b addr=%05h want 1 00200", mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h22;
    tick(); mem_ack = 1'b0;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h22}) $display("FAIL pend_second_resp: got v=%0b d=%02h want 1 22", rd_valid, rd_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 0;
    rd_req = 1'b1; rd_addr = 18'h00500;
    tick(); rd_req = 1'b0;
    tick();
    while (mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    $display("timeout read 00500: req_cycles=%0d rd_data=%02h err=%0b", cnt, rd_data, err);
    total_cnt++; if (cnt !== 15) $display("FAIL tmo_cycles: got %0d want 15", cnt); else pass_cnt++;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'hFF}) $display("FAIL tmo_resp: got v=%0b d=%02h want 1 ff", rd_valid, rd_data); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL tmo_err: got %0b want 1", err); else pass_cnt++;
    rd_req = 1'b1; rd_addr = 18'h00500;
    tick(); rd_req = 1'b0;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL tmo_no_fill: got %0b want 0", rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL tmo_reread: got %0b want 1", mem_req); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h55;
    tick(); mem_ack = 1'b0;
    total_cnt++; if ({rd_valid, rd_data, err} !== {1'b1, 8'h55, 1'b1}) $display("FAIL tmo_err_sticky: got v=%0b d=%02h err=%0b want 1 55 1", rd_valid, rd_data, err); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    ld_req = 1'b1; ld_addr = 18'h00600; ld_data = 8'h33;
    tick(); ld_req = 1'b0;
    tick();
    total_cnt++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL areset_wr_active: got %02b want 11", {mem_req, mem_we}); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-write: mem_req=%0b ld_busy=%0b err=%0b", mem_req, ld_busy, err);
    total_cnt++; if ({mem_req, ld_busy, err} !== 3'b000) $display("FAIL areset_immediate: got req/busy/err=%03b want 000", {mem_req, ld_busy, err}); else pass_cnt++;
    #2 reset = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 18'h00500;
    tick(); rd_req = 1'b0;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL areset_cache_cleared: got %0b want 0", rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 18'h00500) $display("FAIL areset_miss: got req=%0b addr=%05h want 1 00500", mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'h66;
    tick(); mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1; rd_addr = 18'h00700;
    tick(); rd_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h99;
    rd_req = 1'b1; rd_addr = 18'h00500;
    tick();
    mem_ack = 1'b0; rd_req = 1'b0;
    $display("collision: miss resp v=%0b d=%02h", rd_valid, rd_data);
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h99}) $display("FAIL b2b_miss_first: got v=%0b d=%02h want 1 99", rd_valid, rd_data); else pass_cnt++;
    tick();
    $display("collision: hit resp v=%0b d=%02h", rd_valid, rd_data);
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'h66}) $display("FAIL b2b_hit_delayed: got v=%0b d=%02h want 1 66", rd_valid, rd_data); else pass_cnt++;
    tick();
    total_cnt++; if ({rd_valid, mem_req} !== 2'b00) $display("FAIL b2b_quiet: got v/req=%02b want 00", {rd_valid, mem_req}); else pass_cnt++;
    rd_req = 1'b1; rd_addr = 18'h00800;
    tick(); rd_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hAB;
    rd_req = 1'b1; rd_addr = 18'h00800;
    tick();
    mem_ack = 1'b0; rd_req = 1'b0;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'hAB}) $display("FAIL preack_resp: got v=%0b d=%02h want 1 ab", rd_valid, rd_data); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 18'h00800) $display("FAIL preack_miss: got req=%0b addr=%05h want 1 00800", mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 8'hAB;
    tick(); mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_load_invalidate();
    test_starvation();
    test_pending_overwrite();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
